// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with held grants and registered one-hot/encoded outputs.
// Define RR_ARB_TIMEOUT_EN to compile in the MAX_HOLD grant timeout.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state, state_nx;
   logic [1:0] ptr, ptr_nx, gnt_id_nx, pick_id;
   logic [3:0] gnt_nx, cand;
   logic       pick_vld, owner_req, rearb;
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter4: MAX_HOLD must be within 2..255");
   end
   function automatic logic [2:0] rr_pick(input logic [3:0] m, input logic [1:0] p);
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (m[idx]) rr_pick = {1'b1, idx};
      end
   endfunction
   assign owner_req = |(req & gnt);
   // The owner is masked out so a timeout revoke can never re-pick it.
   assign cand = req & ~gnt;
   assign {pick_vld, pick_id} = rr_pick(cand, ptr);
`ifdef RR_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt, hold_cnt_nx;
   logic       revoke;
   assign revoke = owner_req && |cand && hold_cnt == HOLD_LAST;
   assign rearb = state == IDLE || !owner_req || revoke;
   // Time only accrues under contention, so a rival always gets MAX_HOLD-1 waiting cycles.
   assign hold_cnt_nx = rearb ? 8'd0 : (|cand && hold_cnt != HOLD_LAST) ? hold_cnt + 8'd1 : hold_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hold_cnt <= 8'd0;
      else hold_cnt <= hold_cnt_nx;
`else
   assign rearb = state == IDLE || !owner_req;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = rearb ? (pick_vld ? GRANT : IDLE) : GRANT;
   always_comb begin
      gnt_nx    = rearb ? (pick_vld ? 4'b0001 << pick_id : 4'b0000) : gnt;
      gnt_id_nx = rearb && pick_vld ? pick_id : gnt_id;
      ptr_nx    = rearb && pick_vld ? pick_id + 2'd1 : ptr;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gnt    <= 4'b0000;
         gnt_id <= 2'b00;
         busy   <= 1'b0;
         ptr    <= 2'b00;
      end else begin
         gnt    <= gnt_nx;
         gnt_id <= gnt_id_nx;
         busy   <= |gnt_nx;
         ptr    <= ptr_nx;
      end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed vectors plus a random run against a behavioural round-robin model.
// Expected vectors are packed as {busy, gnt_id, gnt}.
module tb_rr_arbiter4;
   localparam int unsigned MAX_HOLD = 4;
   logic       clk, rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   int         n_chk = 0, n_err = 0;
   int         own = -1, mcnt = 0, max_wait = 0;
   logic [1:0] mptr = 2'd0, mid = 2'd0;
   bit         newg;
   int         waits [4];
   int         hold [4];
   rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_id(gnt_id), .busy(busy)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask
   function automatic logic [6:0] obs();
      return {busy, gnt_id, gnt};
   endfunction
   task automatic tick(input logic [3:0] r);
      req = r;
      @(posedge clk);
      #1;
   endtask
   function automatic int search(input logic [3:0] r, input logic [1:0] p);
      int res = -1;
      for (int k = 3; k >= 0; k--)
         if (r[(int'(p) + k) % 4]) res = (int'(p) + k) % 4;
      return res;
   endfunction
   task automatic model_edge(input logic [3:0] r);
      int c;
      bit regrant = 1'b0;
      logic [3:0] rest;
      newg = 1'b0;
      c = -1;
      if (own < 0 || !r[own]) begin
         regrant = 1'b1;
         c = search(r, mptr);
      end
`ifdef RR_ARB_TIMEOUT_EN
      else begin
         rest = r;
         rest[own] = 1'b0;
         if (rest != 4'b0000) begin
            if (mcnt == int'(MAX_HOLD) - 1) begin
               regrant = 1'b1;
               c = search(rest, mptr);
            end else mcnt++;
         end
      end
`else
      rest = 4'b0000;
`endif
      if (regrant) begin
         if (c >= 0) begin
            own = c; mid = 2'(c); mptr = 2'(c + 1); mcnt = 0; newg = 1'b1;
         end else own = -1;
      end
   endtask
   function automatic logic [6:0] model_vec();
      logic [3:0] g = 4'b0000;
      if (own >= 0) g[own] = 1'b1;
      return {own >= 0, mid, g};
   endfunction
   initial begin
      logic [3:0] rq;
      rst_n = 1'b0;
      req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset", obs(), 7'b0_00_0000);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(4'b0000);
         check("idle", obs(), 7'b0_00_0000);
      end
      // full contention, each owner drops three cycles after its grant
      tick(4'b1111); check("rr0", obs(), 7'b1_00_0001);
      tick(4'b1111); check("rr0h", obs(), 7'b1_00_0001);
      tick(4'b1111); check("rr0h", obs(), 7'b1_00_0001);
      tick(4'b1110); check("rr1", obs(), 7'b1_01_0010);
      tick(4'b1111); check("rr1h", obs(), 7'b1_01_0010);
      tick(4'b1111); check("rr1h", obs(), 7'b1_01_0010);
      tick(4'b1101); check("rr2", obs(), 7'b1_10_0100);
      tick(4'b1111); check("rr2h", obs(), 7'b1_10_0100);
      tick(4'b1111); check("rr2h", obs(), 7'b1_10_0100);
      tick(4'b1011); check("rr3", obs(), 7'b1_11_1000);
      tick(4'b1111); check("rr3h", obs(), 7'b1_11_1000);
      tick(4'b1111); check("rr3h", obs(), 7'b1_11_1000);
      tick(4'b0111); check("rr0wrap", obs(), 7'b1_00_0001);
      tick(4'b0000); check("rr_idle", obs(), 7'b0_00_0000);
      // lone requester 2, then ptr=3 makes 0 win over 2
      for (int i = 0; i < 4; i++) begin
         tick(4'b0100);
         check("solo2", obs(), 7'b1_10_0100);
      end
      tick(4'b0000); check("solo2_rel", obs(), 7'b0_10_0000);
      tick(4'b0101); check("ptr3_pick0", obs(), 7'b1_00_0001);
      tick(4'b0000); check("idle2", obs(), 7'b0_00_0000);
      // requester 1 holds while 3 waits
      tick(4'b0010); check("own1", obs(), 7'b1_01_0010);
`ifdef RR_ARB_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         tick(4'b1010);
         check("to_hold1", obs(), 7'b1_01_0010);
      end
      tick(4'b1010); check("to_revoke1", obs(), 7'b1_11_1000);
      for (int i = 0; i < 3; i++) begin
         tick(4'b1010);
         check("to_hold3", obs(), 7'b1_11_1000);
      end
      tick(4'b1010); check("to_revoke3", obs(), 7'b1_01_0010);
`else
      for (int i = 0; i < 20; i++) begin
         tick(4'b1010);
         check("no_preempt", obs(), 7'b1_01_0010);
      end
`endif
      tick(4'b1000); check("hand3", obs(), 7'b1_11_1000);
      tick(4'b0000); check("idle3", obs(), 7'b0_11_0000);
      // asynchronous reset in the middle of a grant
      tick(4'b0001); check("pre_rst", obs(), 7'b1_00_0001);
      #3 rst_n = 1'b0;
      #1 check("async_rst", obs(), 7'b0_00_0000);
      req = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      tick(4'b1001); check("ptr_reset", obs(), 7'b1_00_0001);
      tick(4'b0000); check("idle4", obs(), 7'b0_00_0000);
      // random run against the model
      rst_n = 1'b0;
      #20 rst_n = 1'b1;
      rq = 4'b0000;
      for (int i = 0; i < 4; i++) begin waits[i] = 0; hold[i] = 0; end
      for (int n = 0; n < 10000; n++) begin
         tick(rq);
         model_edge(rq);
         check("rand_vec", obs(), model_vec());
         check("onehot", {6'b0, $onehot0(gnt)}, 7'd1);
         check("busy_or", {6'b0, busy}, {6'b0, |gnt});
         for (int i = 0; i < 4; i++) begin
            if (!rq[i] || own == i) waits[i] = 0;
            else if (newg) waits[i]++;
            if (waits[i] > max_wait) max_wait = waits[i];
         end
         for (int i = 0; i < 4; i++) begin
            if (rq[i]) begin
               if (own == i) begin
                  if (hold[i] == 0) rq[i] = 1'b0;
                  else hold[i]--;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               rq[i] = 1'b1;
               hold[i] = int'($urandom_range(0, 4));
            end
         end
      end
      check("starve", {6'b0, max_wait <= 3}, 7'd1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource, such as the 2-to-4 decoded select path, between four masters. It registers a one-hot grant plus its 2-bit encoded index, so the index can drive a decoder select directly. Grants are held until the owner drops its request. Priority rotates so that no requester starves.

## Interface
Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles while another request is pending. Legal range 2..255. Used only when RR_ARB_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 4: request vector; req[i] is held high by requester i until it is done.
- gnt, output, 4: registered one-hot grant; all zeros when idle.
- gnt_id, output, 2: registered binary index of the current or last owner.
- busy, output, 1: registered; high whenever gnt is non-zero.

## Operation
- State machine with two states:
  - IDLE: gnt = 0.
  - GRANT: exactly one gnt bit is set.
- Rotating pointer ptr[1:0] names the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE -> GRANT: any req bit is high. The arbiter grants the first requester in search order, sets gnt_id to its index, and sets ptr to index+1 mod 4.
- GRANT, owner's req still high: hold the grant. Other requests do not preempt it, except through the timeout in Configuration.
- GRANT, owner's req low, other requests pending: on the same edge, grant the next requester in search order from the updated ptr. There is no bubble cycle.
- GRANT, owner's req low, no other request: go to IDLE. gnt and busy clear; gnt_id keeps its last value.
- Requests in search order never include the current owner, because its req is low at release.
- A req bit that rises and falls while another requester holds the grant is never seen. Requesters must hold req until granted.
- ptr wraps from 3 to 0.

## Timing
- Reset (rst_n low, asynchronous):
  - gnt = 4'b0000, gnt_id = 2'b00, busy = 0.
  - ptr = 0, so requester 0 has highest priority first.
  - Hold counter = 0; state = IDLE.
- Reset deasserted mid-grant: the arbiter restarts from IDLE. A previous owner must re-arbitrate.
- Grant latency: req sampled high at edge N with the arbiter idle gives gnt high after edge N. That is one cycle from req to gnt.
- Release latency: owner's req sampled low at edge N gives its gnt low after edge N. The next grant, if any, is visible in the same cycle.
- Simultaneous release and new requests at the same edge are resolved together. The new requests take part in that edge's search.
- gnt, gnt_id and busy are direct flop outputs with no combinational path from req.
- Invariant: gnt is always 0 or one-hot. busy equals the OR of the gnt bits.

## Configuration
- Macro: RR_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on every new grant.
  - It increments each cycle the owner keeps its grant while at least one other req bit is high.
  - It saturates at MAX_HOLD-1 when no other requester is pending.
  - When the counter reaches MAX_HOLD-1 with another request pending, the next edge revokes the grant and hands it to the next requester in search order. This holds even if the owner's req is still high.
  - The revoked owner re-enters arbitration in normal round-robin order.
- When not defined: the counter logic is absent. Grants last until the owner drops req, and MAX_HOLD is ignored.

## Test plan
- Reset, then req = 4'b0000 for 5 cycles: gnt = 0, gnt_id = 0, busy = 0 throughout. Assert rst_n low mid-cycle: outputs clear immediately, without waiting for a clock edge.
- req = 4'b1111 held, each owner drops its req 3 cycles after being granted, then re-raises it: grant order is 0, 1, 2, 3, 0 with no idle cycle between grants. gnt_id follows 0, 1, 2, 3, 0.
- Only req[2] pulsed for 4 cycles: gnt = 4'b0100 one cycle later and for 4 cycles. Then gnt = 0 and busy = 0, gnt_id stays 2, and the next grant to req = 4'b0101 goes to requester 0 (ptr = 3, so the search order is 3, 0).
- req[1] granted, then req[3] raised while req[1] stays high for 20 cycles, with the macro undefined: gnt stays 4'b0010 for all 20 cycles. req[3] is granted the cycle after req[1] drops.
- Same stimulus with RR_ARB_TIMEOUT_EN and MAX_HOLD = 4: gnt = 4'b0010 for exactly 4 cycles after req[3] rises, then 4'b1000. After 4 more cycles it returns to 4'b0010 if req[1] is still high.
- Random req for 10k cycles against a reference model: gnt is always 0 or one-hot, and busy equals the OR of gnt. No requester holding req waits through more than 3 other grants (also checked with the timeout enabled).
